// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector family.
package seq_detect_pkg;

  localparam int unsigned MASK_W      = 32;
  localparam int unsigned DEF_MAX_LEN = 8;

  localparam logic [DEF_MAX_LEN-1:0] DEF_PATTERN = 8'b0000_1011;
  localparam int unsigned            DEF_LEN     = 4;
  localparam logic                   DEF_OVERLAP = 1'b1;

  // Length 0 is meaningless, so it is promoted to 1; oversize lengths saturate.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    if (len == 0) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

  function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_detect_prog_if.sv
// Config, serial-input and result signals of the programmable pattern detector.
interface seq_detect_prog_if #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned CNT_W   = 8
);
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               count_clr;
  logic               inp_valid;
  logic               inp_bit;
  logic               seq_seen;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap, count_clr, inp_valid, inp_bit,
    input  seq_seen, match_count
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, count_clr, inp_valid, inp_bit,
    output seq_seen, match_count
  );
endinterface

// File: rtl/seq_match_cmp.sv
// Combinational masked compare of the next history against the active pattern.
module seq_match_cmp
  import seq_detect_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4
) (
  input  logic [MAX_LEN-1:0] hist_next,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   fill_next,
  input  logic [LEN_W-1:0]   len,
  output logic               match_c
);

  logic [MAX_LEN-1:0] mask;

  // Only the low len bits take part; a match also needs len bits accepted.
  always_comb begin
    mask    = MAX_LEN'(len_mask(32'(len)));
    match_c = (fill_next == len) && (((hist_next ^ pattern) & mask) == '0);
  end

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector with overlap mode and saturating match count.
module seq_detect_prog #(
  parameter int unsigned        MAX_LEN     = 8,
  parameter int unsigned        LEN_W       = 4,
  parameter int unsigned        CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(seq_detect_pkg::DEF_PATTERN),
  parameter int unsigned        DEF_LEN     = seq_detect_pkg::DEF_LEN,
  parameter logic               DEF_OVERLAP = seq_detect_pkg::DEF_OVERLAP
) (
  input  logic              clk,
  input  logic              reset,
  seq_detect_prog_if.slave  bus
);
  import seq_detect_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [MAX_LEN-1:0] history_q;
  logic [LEN_W-1:0]   fill_q;
  logic               seq_seen_q;
  logic [CNT_W-1:0]   count_q;

  logic               accept_c;
  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_next;
  logic [LEN_W-1:0]   cfg_len_clamped;
  logic               hit_c;
  logic               match_c;

  // Next-value datapath; cfg_load steals the cycle from the serial input.
  always_comb begin
    accept_c        = bus.inp_valid & ~bus.cfg_load;
    hist_next       = {history_q[MAX_LEN-2:0], bus.inp_bit};
    fill_next       = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
    cfg_len_clamped = LEN_W'(clamp_len(32'(bus.cfg_len), MAX_LEN));
    match_c         = accept_c & hit_c;
  end

  seq_match_cmp #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cmp (
    .hist_next (hist_next),
    .pattern   (pattern_q),
    .fill_next (fill_next),
    .len       (len_q),
    .match_c   (hit_c)
  );

  // Config, history and match pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q  <= DEF_PATTERN;
      len_q      <= LEN_W'(DEF_LEN);
      overlap_q  <= DEF_OVERLAP;
      history_q  <= '0;
      fill_q     <= '0;
      seq_seen_q <= 1'b0;
    end else if (bus.cfg_load) begin
      pattern_q  <= bus.cfg_pattern;
      len_q      <= cfg_len_clamped;
      overlap_q  <= bus.cfg_overlap;
      history_q  <= '0;
      fill_q     <= '0;
      seq_seen_q <= 1'b0;
    end else if (accept_c) begin
      history_q  <= hist_next;
      // Non-overlap restarts the fill so a fresh len bits are needed.
      fill_q     <= (match_c && !overlap_q) ? '0 : fill_next;
      seq_seen_q <= match_c;
    end else begin
      seq_seen_q <= 1'b0;
    end
  end

  // Saturating match counter; a clear wins over a coincident match.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (bus.count_clr) begin
      count_q <= '0;
    end else if (match_c && (count_q != CNT_MAX)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.seq_seen    = seq_seen_q;
  assign bus.match_count = count_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: directed scenarios plus random traffic against a queue-based model.
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_load, d_overlap, d_clr, d_valid, d_bit;
  logic [7:0] d_pat;
  logic [3:0] d_len;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of bits accepted since the last clear, newest at the back.
  bit         m_hist[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_seen;
  int         m_cnt8;
  int         m_cnt2;

  seq_detect_prog_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) if8 ();
  seq_detect_prog_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) if2 ();

  assign if8.cfg_load    = d_load;
  assign if8.cfg_pattern = d_pat;
  assign if8.cfg_len     = d_len;
  assign if8.cfg_overlap = d_overlap;
  assign if8.count_clr   = d_clr;
  assign if8.inp_valid   = d_valid;
  assign if8.inp_bit     = d_bit;
  assign if2.cfg_load    = d_load;
  assign if2.cfg_pattern = d_pat;
  assign if2.cfg_len     = d_len;
  assign if2.cfg_overlap = d_overlap;
  assign if2.count_clr   = d_clr;
  assign if2.inp_valid   = d_valid;
  assign if2.inp_bit     = d_bit;

  seq_detect_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (if8)
  );

  seq_detect_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model over the same edge, sample 1 time unit later.
  task automatic step(input bit rst, input bit load, input bit v, input bit b, input bit clr,
                      input logic [7:0] pat, input int len, input bit ovl);
    bit match;
    reset = rst; d_load = load; d_valid = v; d_bit = b; d_clr = clr;
    d_pat = pat; d_len = 4'(len); d_overlap = ovl;
    @(posedge clk);
    match = 1'b0;
    if (rst) begin
      m_pat = 8'b0000_1011; m_len = 4; m_ovl = 1'b1;
      m_hist.delete(); m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      if (load) begin
        m_pat = pat;
        m_len = (len == 0) ? 1 : (len > 8) ? 8 : len;
        m_ovl = ovl;
        m_hist.delete();
      end else if (v) begin
        m_hist.push_back(b);
        if (m_hist.size() > 8) void'(m_hist.pop_front());
        match = (m_hist.size() >= m_len);
        for (int k = 0; k < m_len; k++)
          if (match && (m_hist[m_hist.size() - 1 - k] != m_pat[k])) match = 1'b0;
        if (match && !m_ovl) m_hist.delete();
      end
      if (clr) begin
        m_cnt8 = 0; m_cnt2 = 0;
      end else if (match) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    m_seen = match;
    #1;
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic do_load(input logic [7:0] pat, input int len, input bit ovl);
    step(0, 1, 0, 0, 0, pat, len, ovl);
  endtask

  task automatic feed(input bit b);
    step(0, 0, 1, b, 0, 8'h00, 0, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 1, 0, 8'h00, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    checks++;
    if (if8.seq_seen !== 1'b0 || if2.seq_seen !== 1'b0) begin
      errors++; $display("FAIL reset_seen got %b/%b exp 0", if8.seq_seen, if2.seq_seen);
    end
    checks++;
    if (if8.match_count !== 8'd0 || if2.match_count !== 2'd0) begin
      errors++; $display("FAIL reset_count got %0d/%0d exp 0", if8.match_count, if2.match_count);
    end
  endtask

  task automatic test_default_overlap();
    logic [6:0] s = 7'b1011011;
    logic [6:0] exp_pulse = 7'b0001001;
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      feed(s[i]);
      checks++;
      if (if8.seq_seen !== exp_pulse[i] || m_seen !== exp_pulse[i]) begin
        errors++; $display("FAIL dflt_ovl_seen bit %0d got %b exp %b", 7 - i, if8.seq_seen, exp_pulse[i]);
      end
    end
    checks++;
    if (if8.match_count !== 8'd2) begin
      errors++; $display("FAIL dflt_ovl_count got %0d exp 2", if8.match_count);
    end
  endtask

  task automatic test_load_110();
    logic [8:0] s = 9'b110110110;
    logic [3:0] t = 4'b1110;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      do_load(8'b110, 3, pass[0]);
      for (int i = 8; i >= 0; i--) begin
        feed(s[i]);
        checks++;
        if (if8.seq_seen !== (i % 3 == 0)) begin
          errors++; $display("FAIL p110_seen ovl %0d bit %0d got %b exp %b", pass, 9 - i, if8.seq_seen, (i % 3 == 0));
        end
      end
      checks++;
      if (if8.match_count !== 8'(3 * (pass + 1))) begin
        errors++; $display("FAIL p110_count ovl %0d got %0d exp %0d", pass, if8.match_count, 3 * (pass + 1));
      end
    end
    for (int i = 3; i >= 0; i--) begin
      feed(t[i]);
      checks++;
      if (if8.seq_seen !== (i == 0) || if2.seq_seen !== m_seen) begin
        errors++; $display("FAIL p110_tail_seen bit %0d got %b exp %b", 4 - i, if8.seq_seen, (i == 0));
      end
    end
  endtask

  task automatic test_default_nonoverlap();
    logic [6:0] s = 7'b1011011;
    do_reset();
    do_load(8'b1011, 4, 0);
    for (int i = 6; i >= 0; i--) begin
      feed(s[i]);
      checks++;
      if (if8.seq_seen !== (i == 3)) begin
        errors++; $display("FAIL nonovl_seen bit %0d got %b exp %b", 7 - i, if8.seq_seen, (i == 3));
      end
    end
    checks++;
    if (if8.match_count !== 8'd1) begin
      errors++; $display("FAIL nonovl_count got %0d exp 1", if8.match_count);
    end
  endtask

  task automatic test_idle();
    do_reset();
    feed(1); feed(0); feed(1);
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++;
      if (if8.seq_seen !== 1'b0) begin
        errors++; $display("FAIL idle_seen cycle %0d got %b exp 0", i, if8.seq_seen);
      end
    end
    feed(1);
    checks++;
    if (if8.seq_seen !== 1'b1 || if8.match_count !== 8'd1) begin
      errors++; $display("FAIL idle_final got %b/%0d exp 1/1", if8.seq_seen, if8.match_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    feed(1); feed(0); feed(1);
    do_reset();
    feed(1);
    checks++;
    if (if8.seq_seen !== 1'b0 || if8.match_count !== 8'd0) begin
      errors++; $display("FAIL rst_mid got %b/%0d exp 0/0", if8.seq_seen, if8.match_count);
    end
    feed(1); feed(0); feed(1); feed(1);
    feed(1); feed(0); feed(1);
    do_load(8'b1011, 4, 1);
    feed(1);
    checks++;
    if (if8.seq_seen !== 1'b0 || if8.match_count !== 8'd1) begin
      errors++; $display("FAIL load_mid got %b/%0d exp 0/1", if8.seq_seen, if8.match_count);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    do_load(8'h01, 1, 1);
    for (int i = 1; i <= 10; i++) begin
      feed(1);
      checks++;
      if (if8.seq_seen !== 1'b1 || if2.seq_seen !== 1'b1 || if2.match_count !== 2'(i > 3 ? 3 : i)) begin
        errors++; $display("FAIL sat_step %0d got %b/%0d exp 1/%0d", i, if2.seq_seen, if2.match_count, i > 3 ? 3 : i);
      end
    end
    checks++;
    if (if8.match_count !== 8'd10 || if2.match_count !== 2'd3) begin
      errors++; $display("FAIL sat_count got %0d/%0d exp 10/3", if8.match_count, if2.match_count);
    end
    step(0, 0, 1, 1, 1, 8'h00, 0, 0);
    checks++;
    if (if8.seq_seen !== 1'b1 || if8.match_count !== 8'd0 || if2.match_count !== 2'd0) begin
      errors++; $display("FAIL clr_with_match got %b/%0d/%0d exp 1/0/0", if8.seq_seen, if8.match_count, if2.match_count);
    end
  endtask

  task automatic test_len_clamp();
    logic [3:0]  s = 4'b0110;
    logic [15:0] w = 16'hA5A5;
    do_reset();
    do_load(8'h01, 0, 1);
    for (int i = 3; i >= 0; i--) begin
      feed(s[i]);
      checks++;
      if (if8.seq_seen !== s[i]) begin
        errors++; $display("FAIL len0_seen bit %0d got %b exp %b", 4 - i, if8.seq_seen, s[i]);
      end
    end
    do_load(8'hA5, 15, 1);
    for (int i = 15; i >= 0; i--) begin
      feed(w[i]);
      checks++;
      if (if8.seq_seen !== (i % 8 == 0)) begin
        errors++; $display("FAIL len15_seen bit %0d got %b exp %b", 16 - i, if8.seq_seen, (i % 8 == 0));
      end
    end
    checks++;
    if (if8.match_count !== 8'd4) begin
      errors++; $display("FAIL clamp_count got %0d exp 4", if8.match_count);
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      step(r == 0, (r >= 1 && r <= 6), ($urandom_range(0, 3) != 0), 1'($urandom),
           (r >= 7 && r <= 9), 8'($urandom), $urandom_range(0, 15), 1'($urandom));
      checks++;
      if (if8.seq_seen !== m_seen || if2.seq_seen !== m_seen) begin
        errors++; $display("FAIL rand_seen cyc %0d got %b/%b exp %b", i, if8.seq_seen, if2.seq_seen, m_seen);
      end
      checks++;
      if (if8.match_count !== 8'(m_cnt8) || if2.match_count !== 2'(m_cnt2)) begin
        errors++; $display("FAIL rand_count cyc %0d got %0d/%0d exp %0d/%0d", i, if8.match_count, if2.match_count, m_cnt8, m_cnt2);
      end
    end
  endtask

  initial begin
    reset = 1'b1; d_load = 1'b0; d_valid = 1'b0; d_bit = 1'b0; d_clr = 1'b0;
    d_pat = 8'h00; d_len = 4'h0; d_overlap = 1'b0;
    test_reset();
    test_default_overlap();
    test_load_110();
    test_default_nonoverlap();
    test_idle();
    test_reset_mid();
    test_saturate();
    test_len_clamp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
- Runtime-programmable serial pattern detector; parametrised successor of the fixed 1011 detector.
- Detects a pattern of 1..MAX_LEN bits on a 1-bit stream qualified by inp_valid.
- Overlapping or non-overlapping match mode; saturating match counter.
- Sits on serial-input paths (framing/sync-word detection) alongside existing detector blocks.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, 4, width of cfg_len; must hold MAX_LEN.
- CNT_W, 8, width of match_count.
- DEF_PATTERN, 8'b0000_1011, reset pattern, right-aligned.
- DEF_LEN, 4, reset pattern length.
- DEF_OVERLAP, 1, reset overlap mode.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- cfg_load  input  1  latch cfg_pattern/cfg_len/cfg_overlap this cycle.
- cfg_pattern  input  MAX_LEN  pattern, right-aligned; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  input  LEN_W  pattern length.
- cfg_overlap  input  1  1 = overlapping matches allowed.
- count_clr  input  1  clear match_count.
- inp_valid  input  1  inp_bit is sampled this cycle.
- inp_bit  input  1  serial data.
- seq_seen  output  1  registered one-cycle match pulse.
- match_count  output  CNT_W  saturating number of matches.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- On reset:
  - pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP.
  - history=0, fill=0, seq_seen=0, match_count=0.
- State:
  - history: MAX_LEN-bit shift register.
  - fill: count of accepted bits, 0..len, saturating at len.
  - Active config registers.
- Accept: inp_valid=1 and cfg_load=0 and reset=0.
  - hist_next = {history[MAX_LEN-2:0], inp_bit}.
  - fill_next = min(fill+1, len).
- Match condition (combinational on next values):
  - fill_next==len and hist_next[len-1:0]==pattern[len-1:0].
  - Bits at index >= len are ignored.
- seq_seen:
  - Registered. High for exactly the one cycle following the edge that accepted the completing bit; low otherwise.
  - Latency is 1 clk from the final bit's sampling edge.
  - Back-to-back matches give consecutive high cycles.
- Overlap mode:
  - Overlap=1: after a match, history is kept, so a suffix may start the next match.
  - Overlap=0: after a match, fill is forced to 0. History value is irrelevant, so no match is possible until len new bits are accepted.
- inp_valid=0: history, fill and count hold; seq_seen=0 next cycle.
- cfg_load=1:
  - Latch the new config.
  - Clear history and fill.
  - seq_seen=0 next cycle.
  - inp_bit is ignored that cycle; match_count is unaffected.
  - cfg_load has priority over inp_valid.
- cfg_len clamp at load: 0 becomes 1; values >MAX_LEN become MAX_LEN. Pattern bits are stored unchanged.
- match_count:
  - Increments by 1 per match and saturates at 2^CNT_W-1.
  - count_clr=1 sets it to 0 next cycle. A match in the same cycle is dropped, so the count is 0, not 1. seq_seen still pulses.
- Reset mid-pattern discards all partial history; reset has priority over all inputs.
- No X propagation: all registers are reset, and the comparison mask derives from the registered len only.

Decomposition:
- Package seq_detect_pkg holds:
  - Default constants DEF_PATTERN, DEF_LEN, DEF_OVERLAP.
  - Function clamp_len(len, max).
  - Function len_mask(len), which returns the MAX_LEN-bit mask of the low len bits.
- One sub-module, seq_match_cmp: purely combinational masked compare of hist_next vs pattern under len_mask, plus the fill==len qualifier. It is reused by future multi-pattern variants.
- All remaining logic lives in seq_detect_prog: registers, fill counter, overlap handling, match counter.

Test Plan:
- Reset defaults, overlap=1; stream 1,0,1,1,0,1,1 with continuous valid -> seq_seen high the cycle after bit 4 and the cycle after bit 7; match_count=2.
- Load pattern=3'b110, len=3, overlap=0; stream 1,1,0,1,1,0,1,1,0 -> three pulses, after bits 3, 6 and 9; match_count=3. Same stream with overlap=1 -> same three pulses. Then 1,1,1,0 -> one pulse after bit 4.
- Default config, overlap=0; stream 1,0,1,1,0,1,1 -> single pulse after bit 4; match_count=1.
- Default config; bits 1,0,1 valid, three idle cycles (inp_valid=0, inp_bit=1), then 1 -> no pulse during idle; pulse after the final bit.
- Bits 1,0,1; assert reset for 1 cycle; then bit 1 -> no pulse, count=0. Repeat with cfg_load instead of reset -> no pulse, count unchanged.
- CNT_W=2, pattern 1/len=1, ten 1s -> ten pulses; match_count saturates at 3. Then count_clr coincident with a match -> count=0, seq_seen=1.
- cfg_len=0 -> behaves as len=1. cfg_len=15 with MAX_LEN=8 -> behaves as len=8.
